// File: rtl/reg_bus_arb_if.sv
// Register access bus bundle for reg_bus_arb: two requesting masters on one side,
// the user-logic register file on the other.
//   slave  : arbiter view (takes master requests, drives the register bus)
//   master : environment view (issues master requests, acts as the register file)
interface reg_bus_arb_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) ();

  // master 0: host BAR path
  logic                  m0_req;
  logic                  m0_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  // master 1: local debug / self-test master
  logic                  m1_req;
  logic                  m1_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  // register file bus
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic [DATA_WIDTH-1:0] cpu_data_out;

  // status
  logic                  addr_err;
  logic                  busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  cpu_data_out,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output cpu_wr, cpu_rd, cpu_wr_addr, cpu_data_in,
    output addr_err, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output cpu_data_out,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  cpu_wr, cpu_rd, cpu_wr_addr, cpu_data_in,
    input  addr_err, busy
  );

endinterface

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: two-master round-robin arbiter and single-access sequencer for
// the user-logic register bus. One access at a time; reads hold the address for
// RD_LAT+1 cycles and capture cpu_data_out on the last one. Out-of-range
// addresses complete with addr_err and no bus cycle. All outputs are registered.
module reg_bus_arb #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RD_LAT     = 1,
  parameter int unsigned           REG_NUM    = 10,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input logic          clks,
  input logic          reset,
  reg_bus_arb_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    ERR,
    ACK
  } state_t;

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM);
  localparam logic [2:0]          RD_LAST   = 3'(RD_LAT);

  // FSM and latched request
  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;            // 0 = master 0, 1 = master 1
  logic                  last_gnt_q, last_gnt_d;
  logic                  lat_wr_q, lat_wr_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic [2:0]            rd_cnt_q, rd_cnt_d;

  // registered outputs
  logic                  cpu_wr_q, cpu_wr_d;
  logic                  cpu_rd_q, cpu_rd_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_WIDTH-1:0] cpu_din_q, cpu_din_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  addr_err_q, addr_err_d;
  logic                  busy_q, busy_d;

  // State register and latched request fields
  always_ff @(posedge clks) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      lat_wr_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      lat_wr_q    <= lat_wr_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // Arbitration and next-state sequencing
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    lat_wr_d    = lat_wr_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rd_cnt_d    = rd_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // pointer only moves on real contention
          if (bus.m0_req && bus.m1_req) begin
            gnt_d      = ~last_gnt_q;
            last_gnt_d = ~last_gnt_q;
          end else begin
            gnt_d = bus.m1_req;
          end
          lat_wr_d    = gnt_d ? bus.m1_wr    : bus.m0_wr;
          lat_addr_d  = gnt_d ? bus.m1_addr  : bus.m0_addr;
          lat_wdata_d = gnt_d ? bus.m1_wdata : bus.m0_wdata;
          if ({1'b0, lat_addr_d} >= REG_LIMIT) begin
            state_d = ERR;
          end else if (lat_wr_d) begin
            state_d = WR;
          end else begin
            state_d  = RD;
            rd_cnt_d = '0;
          end
        end
      end
      WR:  state_d = ACK;
      ERR: state_d = ACK;
      RD: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d = ACK;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    cpu_wr_d   = (state_d == WR);
    cpu_rd_d   = (state_d == RD);
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    ack0_d     = (state_d == ACK) && !gnt_d;
    ack1_d     = (state_d == ACK) &&  gnt_d;
    addr_err_d = (state_q == ERR);
    busy_d     = (state_d != IDLE);
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    // bus address/data only move when a real access starts, otherwise they hold
    if (state_q == IDLE && (state_d == WR || state_d == RD)) begin
      cpu_addr_d = lat_addr_d;
    end
    if (state_q == IDLE && state_d == WR) begin
      cpu_din_d = lat_wdata_d;
    end

    // read data lands in the granted master's register at the RD->ACK edge
    if (state_q == RD && state_d == ACK) begin
      if (gnt_q) rdata1_d = bus.cpu_data_out;
      else       rdata0_d = bus.cpu_data_out;
    end
    if (state_q == ERR && !lat_wr_q) begin
      if (gnt_q) rdata1_d = ERR_DATA;
      else       rdata0_d = ERR_DATA;
    end
  end

  // Output registers
  always_ff @(posedge clks) begin
    if (!reset) begin
      cpu_wr_q   <= 1'b0;
      cpu_rd_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cpu_wr_q   <= cpu_wr_d;
      cpu_rd_q   <= cpu_rd_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cpu_wr      = cpu_wr_q;
  assign bus.cpu_rd      = cpu_rd_q;
  assign bus.cpu_wr_addr = cpu_addr_q;
  assign bus.cpu_data_in = cpu_din_q;
  assign bus.m0_ack      = ack0_q;
  assign bus.m1_ack      = ack1_q;
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Testbench for reg_bus_arb: scoreboard of expected completions produced by a
// transaction-level model (register array, round-robin pointer, last read data
// per master); a negedge monitor checks bus strobes and acks against it.
module tb_reg_bus_arb;

  localparam int unsigned     AW       = 12;
  localparam int unsigned     DW       = 32;
  localparam int unsigned     RD_LAT   = 1;
  localparam int unsigned     REG_NUM  = 10;
  localparam logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF;

  logic clks  = 1'b0;
  logic reset = 1'b0;

  reg_bus_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_bus_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LAT    (RD_LAT),
    .REG_NUM   (REG_NUM),
    .ERR_DATA  (ERR_DATA)
  ) dut (
    .clks (clks),
    .reset(reset),
    .bus  (bus)
  );

  initial forever #5 clks = ~clks;

  // ---------------- register file model (slave) ----------------
  logic [DW-1:0] slv_mem  [1<<AW];
  logic [DW-1:0] slv_pipe [RD_LAT];
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clks) begin
    if (pre_en) slv_mem[pre_addr] <= pre_data;
    else if (bus.cpu_wr) slv_mem[bus.cpu_wr_addr] <= bus.cpu_data_in;
    slv_pipe[0] <= slv_mem[bus.cpu_wr_addr];
    for (int i = 1; i < int'(RD_LAT); i++) slv_pipe[i] <= slv_pipe[i-1];
  end
  assign bus.cpu_data_out = slv_pipe[RD_LAT-1];

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic          m;
    logic          wr;
    logic          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mdl_mem [1<<AW];
  logic          mdl_last = 1'b1;
  logic [DW-1:0] mdl_rd [2];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void serve(logic m, logic wr, logic [AW-1:0] addr, logic [DW-1:0] wd);
    exp_t e;
    e.m     = m;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wd;
    e.err   = (int'(addr) >= int'(REG_NUM));
    if (wr && !e.err) mdl_mem[addr] = wd;
    if (!wr) mdl_rd[m] = e.err ? ERR_DATA : mdl_mem[addr];
    e.rdata = mdl_rd[m];
    sb_q.push_back(e);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!m) begin
      bus.m0_req = 1'b1; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = 1'b1; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    mdl_mem[a] = d;
    @(negedge clks);
    pre_en = 1'b0;
  endtask

  // Issue requests from one or both masters at a negedge, run until all acked.
  task automatic do_round(input logic r0, input logic wr0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic r1, input logic wr1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic done0, done1, first;
    if (r0) drive(1'b0, wr0, a0, d0);
    if (r1) drive(1'b1, wr1, a1, d1);
    if (r0 && r1) begin
      first    = ~mdl_last;
      mdl_last = first;
      if (!first) begin serve(1'b0, wr0, a0, d0); serve(1'b1, wr1, a1, d1); end
      else        begin serve(1'b1, wr1, a1, d1); serve(1'b0, wr0, a0, d0); end
    end else if (r0) serve(1'b0, wr0, a0, d0);
    else if (r1)     serve(1'b1, wr1, a1, d1);
    done0 = !r0;
    done1 = !r1;
    for (int c = 0; c < 100 && !(done0 && done1); c++) begin
      @(posedge clks); #1;
      if (bus.m0_ack) begin bus.m0_req = 1'b0; done0 = 1'b1; end
      if (bus.m1_ack) begin bus.m1_req = 1'b0; done1 = 1'b1; end
    end
    chk("round_complete", {done0, done1}, 2'b11);
    @(negedge clks);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom);
    return AW'($urandom_range(0, REG_NUM + 1));
  endfunction

  // ---------------- monitor ----------------
  int unsigned mon_cyc = 0, mon_start = 0, mon_rd = 0, mon_wr = 0;
  logic        mon_prev_busy = 1'b0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clks);
      if (!reset) begin
        mon_prev_busy = 1'b0;
        mon_rd = 0;
        mon_wr = 0;
      end else begin
        mon_cyc++;
        if (bus.busy && !mon_prev_busy) begin
          mon_start = mon_cyc; mon_rd = 0; mon_wr = 0;
        end
        mon_prev_busy = bus.busy;
        if (bus.cpu_wr || bus.cpu_rd) begin
          chk("strobe_exclusive", bus.cpu_wr & bus.cpu_rd, 0);
          chk("strobe_has_txn", sb_q.size() != 0, 1);
          chk("strobe_busy", bus.busy, 1);
        end
        if (bus.cpu_wr && sb_q.size() != 0) begin
          mon_wr++;
          mon_e = sb_q[0];
          chk("wr_kind", {mon_e.wr, mon_e.err}, 2'b10);
          chk("wr_addr", bus.cpu_wr_addr, mon_e.addr);
          chk("wr_data", bus.cpu_data_in, mon_e.wdata);
          chk("wr_cycle", mon_cyc - mon_start, 0);
        end
        if (bus.cpu_rd && sb_q.size() != 0) begin
          mon_rd++;
          mon_e = sb_q[0];
          chk("rd_kind", {mon_e.wr, mon_e.err}, 2'b00);
          chk("rd_addr", bus.cpu_wr_addr, mon_e.addr);
          chk("rd_window", (mon_cyc - mon_start) <= RD_LAT, 1);
        end
        if (bus.m0_ack || bus.m1_ack) begin
          chk("ack_exclusive", bus.m0_ack & bus.m1_ack, 0);
          chk("ack_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("ack_master", bus.m1_ack, mon_e.m);
            chk("ack_latency", mon_cyc - mon_start, (mon_e.wr || mon_e.err) ? 1 : RD_LAT + 1);
            chk("addr_err", bus.addr_err, mon_e.err);
            chk("rdata", mon_e.m ? bus.m1_rdata : bus.m0_rdata, mon_e.rdata);
            chk("rd_cycles", mon_rd, (!mon_e.wr && !mon_e.err) ? RD_LAT + 1 : 0);
            chk("wr_cycles", mon_wr, (mon_e.wr && !mon_e.err) ? 1 : 0);
          end
        end else if (bus.addr_err) begin
          chk("addr_err_without_ack", bus.addr_err, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic          found;
    int            mode;
    logic [DW-1:0] d;

    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    @(negedge clks);

    // fill the register file with random contents while held in reset
    for (int i = 0; i < int'(REG_NUM); i++) preload(AW'(i), DW'($urandom));

    // reset with both masters requesting
    d = DW'($urandom);
    drive(1'b0, 1'b1, 12'h003, d);
    drive(1'b1, 1'b0, 12'h005, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clks);
      chk("reset_outputs",
          {bus.m0_ack, bus.m1_ack, bus.cpu_wr, bus.cpu_rd, bus.addr_err, bus.busy,
           |bus.m0_rdata, |bus.m1_rdata, |bus.cpu_wr_addr, |bus.cpu_data_in}, 0);
    end
    reset = 1'b1;
    do_round(1'b1, 1'b1, 12'h003, d, 1'b1, 1'b0, 12'h005, '0);

    // directed write, then check the register file
    do_round(1'b1, 1'b1, 12'h002, 32'h1234_5678, 1'b0, 1'b0, '0, '0);
    chk("slave_reg2", slv_mem[2], 32'h1234_5678);

    // directed read from master 1
    preload(12'h000, 32'h2018_0612);
    do_round(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h000, '0);

    // three back-to-back contentions
    for (int i = 0; i < 3; i++)
      do_round(1'b1, 1'($urandom), AW'($urandom_range(0, REG_NUM - 1)), DW'($urandom),
               1'b1, 1'($urandom), AW'($urandom_range(0, REG_NUM - 1)), DW'($urandom));

    // illegal address read and write
    do_round(1'b1, 1'b0, 12'h00A, '0, 1'b0, 1'b0, '0, '0);
    do_round(1'b1, 1'b1, 12'h00A, DW'($urandom), 1'b0, 1'b0, '0, '0);

    // reset in the middle of a master 1 read
    drive(1'b1, 1'b0, 12'h004, '0);
    serve(1'b1, 1'b0, 12'h004, '0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clks); #1;
      found = bus.busy;
    end
    chk("abort_read_started", found, 1);
    @(posedge clks); #1;
    reset      = 1'b0;
    bus.m1_req = 1'b0;
    sb_q.delete();
    mdl_last  = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    @(negedge clks);
    @(negedge clks);
    chk("abort_cpu_rd", bus.cpu_rd, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_ack", bus.m1_ack, 0);
    @(negedge clks);
    reset = 1'b1;
    do_round(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h004, '0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(1, 3));
      do_round(mode[0], 1'($urandom), rand_addr(), DW'($urandom),
               mode[1], 1'($urandom), rand_addr(), DW'($urandom));
    end

    repeat (5) @(negedge clks);
    chk("scoreboard_drained", sb_q.size(), 0);
    for (int i = 0; i < int'(REG_NUM); i++) chk("final_register", slv_mem[i], mdl_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
